// File: rtl/mac_stream_ctrl.sv
// mac_stream_ctrl: stream-side driver for the 3x3 matrix MAC.
// Collects A and B as serial elements, packs them into flattened words,
// runs one MAC operation and streams the captured result back out.
// Optional feature macro: MAC_STREAM_B_REUSE_EN adds cmd_reuse_b_i, which
// lets a command skip loading B and reuse the previously loaded B.
module mac_stream_ctrl #(
    parameter int  VAR_WIDTH  = 8,
    parameter int  MAT_SIZE   = 3,
    localparam int DATA_WIDTH = VAR_WIDTH * MAT_SIZE * MAT_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_opcode_i,
    input  logic                  cmd_accum_i,
    input  logic                  cmd_clr_i,
`ifdef MAC_STREAM_B_REUSE_EN
    input  logic                  cmd_reuse_b_i,
`endif
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [VAR_WIDTH-1:0]  s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [VAR_WIDTH-1:0]  m_data_o,
    output logic                  m_last_o,
    output logic [DATA_WIDTH-1:0] mac_matrixA_o,
    output logic [DATA_WIDTH-1:0] mac_matrixB_o,
    output logic [1:0]            mac_opcode_o,
    output logic                  mac_enable_o,
    output logic                  mac_clr_o,
    input  logic [DATA_WIDTH-1:0] mac_result_i,
    output logic                  busy_o
);

    localparam int              N    = MAT_SIZE * MAT_SIZE;
    localparam int              CW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [1:0]            op_q, op_d;
    logic                  accum_q, accum_d;
    logic                  clr_q, clr_d;
    logic                  reuse_q, reuse_d;

    // Handshake-qualified flags; status outputs are flops so every qualifier
    // here is a registered signal.
    logic                  cmd_ready_q, s_ready_q, m_valid_q, m_last_q;
    logic                  en_q, mclr_q, busy_q;
    logic                  cmd_fire_s, s_fire_s, m_fire_s;

    assign cmd_fire_s = cmd_valid_i && cmd_ready_q;
    assign s_fire_s   = s_valid_i && s_ready_q;
    assign m_fire_s   = m_ready_i && m_valid_q;

    // Next-state, counter and datapath register update for the whole FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        accum_d = accum_q;
        clr_d   = clr_q;
        reuse_d = reuse_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire_s) begin
                    op_d    = cmd_opcode_i;
                    accum_d = cmd_accum_i;
                    clr_d   = cmd_clr_i;
`ifdef MAC_STREAM_B_REUSE_EN
                    reuse_d = cmd_reuse_b_i;
`else
                    reuse_d = 1'b0;
`endif
                    cnt_d   = '0;
                    state_d = S_LOAD_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: begin
                if (s_fire_s) begin
                    a_d[DATA_WIDTH-1-int'(cnt_q)*VAR_WIDTH -: VAR_WIDTH] = s_data_i;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = reuse_q ? S_EXEC : S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_B: begin
                if (s_fire_s) begin
                    b_d[DATA_WIDTH-1-int'(cnt_q)*VAR_WIDTH -: VAR_WIDTH] = s_data_i;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_LOAD_B;
                end
            end
            S_EXEC: begin
                // MAC inputs have been stable all cycle; take its output now.
                res_d   = mac_result_i;
                cnt_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (m_fire_s) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = clr_q ? S_CLEAR : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath registers and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= 2'b00;
            accum_q     <= 1'b0;
            clr_q       <= 1'b0;
            reuse_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            en_q        <= 1'b0;
            mclr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            op_q        <= op_d;
            accum_q     <= accum_d;
            clr_q       <= clr_d;
            reuse_q     <= reuse_d;
            cmd_ready_q <= (state_d == S_IDLE);
            s_ready_q   <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            m_valid_q   <= (state_d == S_DRAIN);
            m_last_q    <= (state_d == S_DRAIN) && (cnt_d == LAST);
            en_q        <= (state_d == S_EXEC) && accum_d && op_d[1];
            mclr_q      <= (state_d == S_CLEAR);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign s_ready_o     = s_ready_q;
    assign m_valid_o     = m_valid_q;
    assign m_last_o      = m_last_q;
    assign m_data_o      = res_q[DATA_WIDTH-1-int'(cnt_q)*VAR_WIDTH -: VAR_WIDTH];
    assign mac_matrixA_o = a_q;
    assign mac_matrixB_o = b_q;
    assign mac_opcode_o  = op_q;
    assign mac_enable_o  = en_q;
    assign mac_clr_o     = mclr_q;
    assign busy_o        = busy_q;

endmodule
